// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock,
// signed or unsigned operands, start/busy/done handshake with a registered product.
module booth_radix4_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           tc,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] Z,
  output logic           busy,
  output logic           done
);

  localparam int W   = N + 2;          // extended operand width
  localparam int ACC = 2 * N + 4;      // accumulator width
  localparam int K   = N / 2 + 1;      // digits retired per multiply
  localparam int CW  = $clog2(K + 1);

  if (N < 4 || (N % 2) != 0) begin : g_bad_n
    $error("booth_radix4_seq_mult: N must be even and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC-1:0]   mcand_q, mcand_d;
  logic [ACC-1:0]   acc_q,   acc_d;
  logic [W:0]       mplr_q,  mplr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [2*N-1:0]   z_q,     z_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [W-1:0]     a_ext, b_ext;
  logic [ACC-1:0]   pp_mag, pp_add, pp_cin;
  logic             pp_neg;

  assign a_ext = {{2{tc & A[N-1]}}, A};
  assign b_ext = {{2{tc & B[N-1]}}, B};

  // Booth recoding of the low multiplier triplet; negation is ~x plus a carry-in.
  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp_mag = mcand_q;
      3'b011:         pp_mag = mcand_q << 1;
      3'b100: begin
        pp_mag = mcand_q << 1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = mcand_q;
        pp_neg = 1'b1;
      end
      default: pp_mag = '0;
    endcase
    pp_add = pp_neg ? ~pp_mag : pp_mag;
    pp_cin = {{(ACC-1){1'b0}}, pp_neg};
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = {{(ACC-W){a_ext[W-1]}}, a_ext};
          mplr_d  = {b_ext, 1'b0};
          acc_d   = '0;
          cnt_d   = CW'(K);
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        // Weight advances by shifting the multiplicand left, not the accumulator right.
        acc_d   = acc_q + pp_add + pp_cin;
        mcand_d = mcand_q << 2;
        mplr_d  = {{2{mplr_q[W]}}, mplr_q[W:2]};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          z_d     = acc_d[2*N-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Z    = z_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench: N=4, 8 and 16 instances against an arithmetic product model,
// directed corners, reset abort, handshake and randomized operands.
module tb_booth_radix4_seq_mult;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  start_v;
  logic        tc_in;
  logic [15:0] a_in, b_in;

  logic [7:0]  z4;
  logic [15:0] z8;
  logic [31:0] z16;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_radix4_seq_mult #(.N(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .tc(tc_in),
    .A(a_in[3:0]), .B(b_in[3:0]), .Z(z4), .busy(busy4), .done(done4));

  booth_radix4_seq_mult #(.N(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .tc(tc_in),
    .A(a_in[7:0]), .B(b_in[7:0]), .Z(z8), .busy(busy8), .done(done8));

  booth_radix4_seq_mult #(.N(16)) u_dut16 (
    .clk(clk), .resetn(resetn), .start(start_v[2]), .tc(tc_in),
    .A(a_in), .B(b_in), .Z(z16), .busy(busy16), .done(done16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact product of the operands interpreted per mode, kept to 2n bits.
  function automatic logic [31:0] ref_prod(input int n, input bit tcv,
                                           input logic [15:0] a, input logic [15:0] b);
    longint mask = (longint'(1) <<< n) - 1;
    longint sa   = longint'(a) & mask;
    longint sb   = longint'(b) & mask;
    longint p;
    if (tcv && a[n-1]) sa = sa - (longint'(1) <<< n);
    if (tcv && b[n-1]) sb = sb - (longint'(1) <<< n);
    p = (sa * sb) & ((longint'(1) <<< (2 * n)) - 1);
    return p[31:0];
  endfunction

  function automatic int idx_of(input int n);
    return (n == 4) ? 0 : (n == 8) ? 1 : 2;
  endfunction

  function automatic logic done_of(input int idx);
    case (idx)
      0:       return done4;
      1:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic busy_of(input int idx);
    case (idx)
      0:       return busy4;
      1:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [31:0] z_of(input int idx);
    case (idx)
      0:       return 32'(z4);
      1:       return 32'(z8);
      default: return z16;
    endcase
  endfunction

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_of(idx) && lat < 40);
  endtask

  // One multiply from idle: operands are scrambled right after accept,
  // so the product must come from the latched values only.
  task automatic run_check(input string tag, input int n, input bit tcv,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
    int idx = idx_of(n);
    int lat;
    tc_in = tcv; a_in = a; b_in = b;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    tc_in = 1'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
    check({tag, " busy"}, 64'(busy_of(idx)), 64'd1);
    wait_done(idx, lat);
    check({tag, " latency"}, 64'(lat), 64'(n / 2 + 1));
    check({tag, " Z"}, 64'(z_of(idx)), 64'(exp));
    check({tag, " busy@done"}, 64'(busy_of(idx)), 64'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(done_of(idx)), 64'd0);
    check({tag, " Z hold"}, 64'(z_of(idx)), 64'(exp));
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] ra, rb;
    bit rt;

    resetn = 1'b0; start_v = '0; tc_in = 1'b0; a_in = '0; b_in = '0;
    #12;
    check("reset Z", 64'(z8), 64'd0);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    run_check("s8 80x80", 8, 1'b1, 16'h0080, 16'h0080, 32'h4000);
    run_check("s8 FFx01", 8, 1'b1, 16'h00FF, 16'h0001, 32'hFFFF);
    run_check("s8 7Fx80", 8, 1'b1, 16'h007F, 16'h0080, 32'hC080);

    // Asynchronous reset mid-RUN: Z (0xC080 now) must clear without a clock edge.
    tc_in = 1'b0; a_in = 16'h0033; b_in = 16'h0011;
    start_v[1] = 1'b1;
    @(posedge clk); #1; start_v = '0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("rst mid Z", 64'(z8), 64'd0);
    check("rst mid busy", 64'(busy8), 64'd0);
    check("rst mid done", 64'(done8), 64'd0);
    @(negedge clk); resetn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    check("rst no done", 64'(seen), 64'd0);

    run_check("u8 FFxFF", 8, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01);
    run_check("u8 80x02", 8, 1'b0, 16'h0080, 16'h0002, 32'h0100);
    run_check("u8 00xFF", 8, 1'b0, 16'h0000, 16'h00FF, 32'h0000);

    // start pulsed during RUN with other operands is ignored.
    tc_in = 1'b1; a_in = 16'h0012; b_in = 16'h00F4;
    start_v[1] = 1'b1;
    @(posedge clk); #1; start_v = '0;
    @(posedge clk); #1;
    a_in = 16'h0055; b_in = 16'h0066; tc_in = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1; start_v = '0;
    wait_done(1, lat);
    check("ign latency", 64'(lat + 2), 64'd5);
    check("ign Z", 64'(z8), 64'(ref_prod(8, 1'b1, 16'h0012, 16'h00F4)));
    @(posedge clk); #1;
    check("ign no 2nd", 64'(busy8), 64'd0);

    // start held through DONE: back-to-back with no idle cycle.
    tc_in = 1'b0; a_in = 16'h00C3; b_in = 16'h00A5;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    tc_in = 1'b1; a_in = 16'h009D; b_in = 16'h0047;
    wait_done(1, lat);
    check("b2b 1st latency", 64'(lat), 64'd5);
    check("b2b 1st Z", 64'(z8), 64'(ref_prod(8, 1'b0, 16'h00C3, 16'h00A5)));
    @(posedge clk); #1;
    start_v = '0;
    check("b2b busy", 64'(busy8), 64'd1);
    check("b2b done low", 64'(done8), 64'd0);
    wait_done(1, lat);
    check("b2b spacing", 64'(lat + 1), 64'd6);
    check("b2b 2nd Z", 64'(z8), 64'(ref_prod(8, 1'b1, 16'h009D, 16'h0047)));
    @(posedge clk); #1;

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_check("x4", 4, 1'(m), 16'(a), 16'(b), ref_prod(4, 1'(m), 16'(a), 16'(b)));
        end
      end
    end

    for (int i = 0; i < 400; i++) begin
      rt = 1'(i & 1); ra = 16'($urandom); rb = 16'($urandom);
      run_check("r8", 8, rt, ra, rb, ref_prod(8, rt, ra, rb));
    end

    run_check("s16 8000x8000", 16, 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run_check("u16 FFFFxFFFF", 16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    for (int i = 0; i < 2000; i++) begin
      rt = 1'(i & 1); ra = 16'($urandom); rb = 16'($urandom);
      run_check("r16", 16, rt, ra, rb, ref_prod(16, rt, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
